// File: rtl/clc_key_pkg.sv
// rtl/clc_key_pkg.sv - shared constants and state encoding for the Diffie-Hellman stages
package clc_key_pkg;

    localparam int CLC_DW = 32;
    localparam int CLC_RW = 4;
    localparam int CLC_IW = $clog2(CLC_DW);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        MUL    = 3'd2,
        UPD    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/clc_key_mod_mul.sv
// rtl/clc_key_mod_mul.sv - bit-serial modular multiplier, y = a*b mod p in DW cycles after go
module mod_mul_seq
    import clc_key_pkg::*;
#(
    parameter int DW = CLC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] p,
    output logic          rdy,
    output logic [DW-1:0] y
);

    localparam int IW = $clog2(DW);

    logic [DW-1:0] acc_q;
    logic [IW-1:0] idx_q;
    logic          run_q;
    logic          rdy_q;

    // One MSB-first step; the extra top bit absorbs 2*acc and acc+a before reduction.
    function automatic logic [DW-1:0] step(input logic [DW-1:0] acc, input logic bit_i,
                                           input logic [DW-1:0] av, input logic [DW-1:0] pv);
        logic [DW:0] t;
        logic [DW:0] pe;
        pe = {1'b0, pv};
        t  = {acc, 1'b0};
        if (t >= pe) t = t - pe;
        if (bit_i) begin
            t = t + {1'b0, av};
            if (t >= pe) t = t - pe;
        end
        return t[DW-1:0];
    endfunction

    // a, b and p are read live, so the caller holds them from go until rdy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else if (go) begin
            acc_q <= step(DW'(0), b[DW-1], a, p);
            idx_q <= IW'(DW-2);
            run_q <= 1'b1;
            rdy_q <= 1'b0;
        end else if (run_q) begin
            acc_q <= step(acc_q, b[idx_q], a, p);
            if (idx_q == '0) begin
                run_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                idx_q <= idx_q - IW'(1);
            end
        end
    end

    assign rdy = rdy_q;
    assign y   = acc_q;

endmodule

// File: rtl/clc_key.sv
// rtl/clc_key.sv - shared-secret stage, key = r_peer^x mod p by left-to-right square-and-multiply
module clc_key
    import clc_key_pkg::*;
#(
    parameter int DW = CLC_DW,
    parameter int RW = CLC_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic [RW-1:0] r_peer,
    input  logic [DW-1:0] p,
    input  logic [DW-1:0] x,
    output logic [DW-1:0] key,
    output logic          done,
    output logic          busy,
    output logic          err
);

    localparam int IW = $clog2(DW);

    state_t        state_q;
    logic [DW-1:0] p_q, x_q, base_q, res_q, key_q;
    logic [IW-1:0] bidx_q, cyc_q, msb_idx;
    logic          sel_q, go_q, done_q, busy_q, err_q;
    logic [DW-1:0] mul_a, mul_y;
    logic          mul_rdy;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < DW; i++) begin
            if (x_q[i]) msb_idx = i[IW-1:0];
        end
    end

    assign mul_a = sel_q ? base_q : res_q;

    mod_mul_seq #(.DW(DW)) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (go_q),
        .a   (mul_a),
        .b   (res_q),
        .p   (p_q),
        .rdy (mul_rdy),
        .y   (mul_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            x_q     <= '0;
            base_q  <= '0;
            res_q   <= '0;
            key_q   <= '0;
            bidx_q  <= '0;
            cyc_q   <= '0;
            sel_q   <= 1'b0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st) begin
                        p_q     <= p;
                        x_q     <= x;
                        base_q  <= {{(DW-RW){1'b0}}, r_peer};
                        res_q   <= (p == DW'(1)) ? '0 : DW'(1);
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= REDUCE;
                    end
                end
                // p==0 spends one cycle here too, giving the error case its single-cycle latency.
                REDUCE: begin
                    if (p_q != '0 && base_q >= p_q) begin
                        base_q <= base_q - p_q;
                    end else if (p_q == '0 || x_q == '0) begin
                        key_q   <= (p_q == '0) ? '0 : res_q;
                        err_q   <= (p_q == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        bidx_q  <= msb_idx;
                        sel_q   <= 1'b0;
                        cyc_q   <= '0;
                        go_q    <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (cyc_q == IW'(DW-1)) state_q <= UPD;
                    else                    cyc_q   <= cyc_q + IW'(1);
                end
                UPD: begin
                    if (mul_rdy) begin
                        res_q <= mul_y;
                        cyc_q <= '0;
                        if (!sel_q && x_q[bidx_q]) begin
                            sel_q   <= 1'b1;
                            go_q    <= 1'b1;
                            state_q <= MUL;
                        end else if (bidx_q == '0) begin
                            key_q   <= mul_y;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            bidx_q  <= bidx_q - IW'(1);
                            sel_q   <= 1'b0;
                            go_q    <= 1'b1;
                            state_q <= MUL;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key  = key_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_clc_key.sv
// tb/tb_clc_key.sv - self-checking bench for clc_key against a modular-exponent reference model
module tb_clc_key;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [3:0]  r_peer;
    logic [31:0] p;
    logic [31:0] x;
    logic [31:0] key;
    logic        done;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    clc_key dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .r_peer (r_peer),
        .p      (p),
        .x      (x),
        .key    (key),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_key(input logic [3:0] r, input logic [31:0] pp, input logic [31:0] xx);
        longint unsigned m, b, res, e;
        if (pp == 0) return 32'd0;
        m   = pp;
        b   = r % m;
        res = 1 % m;
        e   = xx;
        while (e != 0) begin
            if (e[0]) res = (res * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return res[31:0];
    endfunction

    function automatic int ref_lat(input logic [3:0] r, input logic [31:0] pp, input logic [31:0] xx);
        int n;
        if (pp == 0) return 1;
        n = 0;
        for (int i = 0; i < 32; i++) if (xx[i]) n = i + 1;
        return int'({28'd0, r} / pp) + 1 + 33 * (n + $countones(xx));
    endfunction

    task automatic do_op(input logic [3:0] r, input logic [31:0] pp, input logic [31:0] xx,
                         output int lat, output bit timeout);
        @(negedge clk);
        r_peer = r; p = pp; x = xx; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        lat = 0;
        timeout = 1'b0;
        while (!done) begin
            if (lat > 5000) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; st = 1'b0; r_peer = '0; p = '0; x = '0;
        repeat (3) @(negedge clk);
        checks++; if (key !== 32'd0) begin errors++; $display("FAIL reset_key got=%h exp=0", key); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [3:0]  tr [6] = '{4'd3, 4'd4, 4'd15, 4'd3, 4'd3, 4'd3};
        logic [31:0] tp [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd0, 32'd1};
        logic [31:0] tx [6] = '{32'd6, 32'd3, 32'd2, 32'd0, 32'd6, 32'd6};
        logic [31:0] tk [6] = '{32'd4, 32'd4, 32'd0, 32'd1, 32'd0, 32'd0};
        int          tl [6] = '{166, 133, 103, 1, 1, 169};
        logic        te [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            do_op(tr[i], tp[i], tx[i], lat, to);
            checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout no done within budget", i); end
            checks++; if (key !== tk[i]) begin errors++; $display("FAIL vec%0d_key got=%0d exp=%0d", i, key, tk[i]); end
            checks++; if (err !== te[i]) begin errors++; $display("FAIL vec%0d_err got=%b exp=%b", i, err, te[i]); end
            checks++; if (lat != tl[i]) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, tl[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy_at_done got=%b exp=1", i, busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse got=%b exp=0", i, done); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_after got=%b exp=0", i, busy); end
            checks++; if (key !== tk[i]) begin errors++; $display("FAIL vec%0d_key_held got=%0d exp=%0d", i, key, tk[i]); end
        end
    endtask

    task automatic test_busy_ignore;
        int  lat;
        bit  to;
        @(negedge clk);
        r_peer = 4'd3; p = 32'd5; x = 32'd6; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
        lat = 0;
        to  = 1'b0;
        while (!done) begin
            if (lat > 5000) begin to = 1'b1; break; end
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 10 || lat == 50) begin
                st = 1'b1; r_peer = 4'd9; p = 32'd7; x = 32'd123;
            end else begin
                st = 1'b0;
            end
        end
        st = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL busy_ignore_timeout no done within budget"); end
        checks++; if (key !== 32'd4) begin errors++; $display("FAIL busy_ignore_key got=%0d exp=4", key); end
        checks++; if (lat != 166) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=166", lat); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_requeue got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit to;
        bit seen;
        @(negedge clk);
        r_peer = 4'd3; p = 32'd5; x = 32'd6; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (key !== 32'd0) begin errors++; $display("FAIL midreset_key got=%0d exp=0", key); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle_busy got=%b exp=0", busy); end
        do_op(4'd4, 32'd5, 32'd3, lat, to);
        checks++; if (to) begin errors++; $display("FAIL midreset_fresh_timeout no done within budget"); end
        checks++; if (key !== 32'd4) begin errors++; $display("FAIL midreset_fresh_key got=%0d exp=4", key); end
        checks++; if (lat != 133) begin errors++; $display("FAIL midreset_fresh_latency got=%0d exp=133", lat); end
    endtask

    task automatic test_random;
        logic [3:0]  r;
        logic [31:0] pp, xx, ek;
        int lat, el;
        bit to;
        for (int i = 0; i < 14; i++) begin
            r = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       pp = $urandom_range(1, 20);
                1:       pp = $urandom;
                default: pp = $urandom_range(0, 3);
            endcase
            xx = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ek = ref_key(r, pp, xx);
            el = ref_lat(r, pp, xx);
            do_op(r, pp, xx, lat, to);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout no done within budget", i); end
            checks++; if (key !== ek) begin errors++; $display("FAIL rnd%0d_key r=%0d p=%0d x=%0d got=%0d exp=%0d", i, r, pp, xx, key, ek); end
            checks++; if (err !== (pp == 0)) begin errors++; $display("FAIL rnd%0d_err got=%b exp=%b", i, err, pp == 0); end
            checks++; if (lat != el) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, el); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_busy_ignore;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
